// File: rtl/alu_uart_interface.sv
// alu_uart_interface
// Sequences three received bytes (operand A, operand B, opcode) into
// registered ALU operands, then captures the ALU result and hands it to the
// transmitter with a one-cycle start pulse.
//
// Handshake: rx_done and tx_done are single-cycle pulses sampled on the
// rising clock edge; tx_start is a single-cycle pulse issued one cycle
// after the opcode is accepted, with tx_data held until the next result.
// A byte arriving while a result is executing or being transmitted is
// dropped and latches the sticky overrun flag.
module alu_uart_interface #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NB_DATA-1:0]   rx_data,
    input  logic                 rx_done,
    input  logic                 tx_done,
    output logic                 tx_start,
    output logic [NB_DATA-1:0]   tx_data,
    output logic [NB_DATA-1:0]   alu_a,
    output logic [NB_DATA-1:0]   alu_b,
    output logic [NB_OPCODE-1:0] alu_opcode,
    input  logic [NB_DATA-1:0]   alu_result,
    output logic                 busy,
    output logic                 overrun,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NB_DATA-1:0]     r_alu_a;
    logic [NB_DATA-1:0]     w_alu_a_next;
    logic [NB_DATA-1:0]     r_alu_b;
    logic [NB_DATA-1:0]     w_alu_b_next;
    logic [NB_OPCODE-1:0]   r_opcode;
    logic [NB_OPCODE-1:0]   w_opcode_next;
    logic [NB_DATA-1:0]     r_tx_data;
    logic [NB_DATA-1:0]     w_tx_data_next;
    logic                   r_tx_start;
    logic                   w_tx_start_next;
    logic                   r_overrun;
    logic                   w_overrun_next;

    // Next-state and next-register values; everything holds unless a case says otherwise.
    always_comb begin
        w_state_next    = r_state;
        w_alu_a_next    = r_alu_a;
        w_alu_b_next    = r_alu_b;
        w_opcode_next   = r_opcode;
        w_tx_data_next  = r_tx_data;
        w_tx_start_next = 1'b0;
        w_overrun_next  = r_overrun;
        case (r_state)
            WAIT_A: begin
                if (rx_done) begin
                    w_alu_a_next = rx_data;
                    w_state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_done) begin
                    w_alu_b_next = rx_data;
                    w_state_next = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (rx_done) begin
                    // Upper bits of the opcode byte are intentionally discarded.
                    w_opcode_next = rx_data[NB_OPCODE-1:0];
                    w_state_next  = EXEC;
                end
            end
            EXEC: begin
                // ALU has settled on the registered operands by now.
                w_tx_data_next  = alu_result;
                w_tx_start_next = 1'b1;
                w_state_next    = WAIT_TX;
                if (rx_done) begin
                    w_overrun_next = 1'b1;
                end
            end
            WAIT_TX: begin
                if (tx_done) begin
                    w_state_next = WAIT_A;
                end
                if (rx_done) begin
                    w_overrun_next = 1'b1;
                end
            end
            default: begin
                w_state_next = WAIT_A;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= WAIT_A;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_opcode   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_alu_a    <= w_alu_a_next;
            r_alu_b    <= w_alu_b_next;
            r_opcode   <= w_opcode_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_start <= w_tx_start_next;
            r_overrun  <= w_overrun_next;
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_opcode;
    assign tx_data    = r_tx_data;
    assign tx_start   = r_tx_start;
    assign overrun    = r_overrun;
    assign busy       = (r_state != WAIT_A);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Testbench for alu_uart_interface: table-driven sequences, directed
// corner cases and randomized transactions against a transaction-level model.
module tb_alu_uart_interface;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_opcode;
    logic [7:0] alu_result;
    logic       busy;
    logic       overrun;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp_op;
        logic [7:0] exp_res;
    } vec_t;
    vec_t vecs[8];

    alu_uart_interface #(.NB_DATA(8), .NB_OPCODE(6)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .busy(busy), .overrun(overrun),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    // Stand-in combinational ALU.
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            default: return a ^ 8'h5A;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_opcode);

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Scoreboard: every tx_start pulse must match the oldest expected result.
    always @(negedge clock) begin
        if (reset && tx_start) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL tx_unexpected: tx_data=0x%0h with no result pending", tx_data);
            end else if (tx_data !== exp_q[0]) begin
                failures++;
                $display("FAIL tx_data_sb: got 0x%0h expected 0x%0h", tx_data, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    // Drivers: all start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] d);
        rx_data = d;
        rx_done = 1'b1;
        @(negedge clock);
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Idle gap with occasional stray tx_done pulses, which must be ignored.
    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
            tx_done = ($urandom_range(0, 2) == 0);
            @(negedge clock);
            tx_done = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] a, b, op, res, stray_d;
        logic [7:0] op_list[8];
        logic [1:0] hi;
        logic       m_ovr, stray, sim;
        int         w;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h20, 8'h08};
        vecs[1] = '{8'h09, 8'h04, 8'hE2, 8'h22, 8'h05};
        vecs[2] = '{8'hF0, 8'h3C, 8'h24, 8'h24, 8'h30};
        vecs[3] = '{8'h81, 8'h7F, 8'h20, 8'h20, 8'h00};
        vecs[4] = '{8'h12, 8'h34, 8'hA5, 8'h25, 8'h36};
        vecs[5] = '{8'h00, 8'hFF, 8'h66, 8'h26, 8'hFF};
        vecs[6] = '{8'h0F, 8'h00, 8'h27, 8'h27, 8'hF0};
        vecs[7] = '{8'h80, 8'h03, 8'hC2, 8'h02, 8'h10};
        op_list = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h3F};

        // Reset held with arbitrary input activity.
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'($urandom_range(0, 255));
            rx_done = 1'($urandom_range(0, 1));
            tx_done = 1'($urandom_range(0, 1));
            @(negedge clock);
            check1("rst_tx_start", tx_start, 1'b0);
        end
        check8("rst_alu_a", alu_a, 8'h00);
        check8("rst_alu_b", alu_b, 8'h00);
        check8("rst_opcode", {2'b00, alu_opcode}, 8'h00);
        check8("rst_tx_data", tx_data, 8'h00);
        check1("rst_busy", busy, 1'b0);
        check1("rst_overrun", overrun, 1'b0);
        rx_done = 1'b0;
        tx_done = 1'b0;
        reset   = 1'b1;

        // Table-driven full sequences with cycle-accurate handshake checks.
        for (int i = 0; i < 8; i++) begin
            send_byte(vecs[i].a);
            check8("vec_alu_a", alu_a, vecs[i].a);
            check1("vec_busy_after_a", busy, 1'b1);
            send_byte(vecs[i].b);
            check8("vec_alu_b", alu_b, vecs[i].b);
            exp_q.push_back(vecs[i].exp_res);
            send_byte(vecs[i].op);
            check8("vec_opcode", {2'b00, alu_opcode}, vecs[i].exp_op);
            check1("vec_no_early_start", tx_start, 1'b0);
            @(negedge clock);
            check1("vec_tx_start", tx_start, 1'b1);
            check8("vec_tx_data", tx_data, vecs[i].exp_res);
            @(negedge clock);
            check1("vec_tx_start_single", tx_start, 1'b0);
            check1("vec_busy_wait_tx", busy, 1'b1);
            pulse_tx_done();
            check1("vec_busy_done", busy, 1'b0);
            check8("vec_tx_data_hold", tx_data, vecs[i].exp_res);
            check8("vec_alu_a_hold", alu_a, vecs[i].a);
        end
        check1("no_overrun_yet", overrun, 1'b0);

        // Overrun while waiting for the transmitter.
        send_byte(8'h21);
        send_byte(8'h11);
        exp_q.push_back(8'h10);
        send_byte(8'h22);
        @(negedge clock);
        send_byte(8'h77);
        check1("ovr_set", overrun, 1'b1);
        check8("ovr_alu_a_kept", alu_a, 8'h21);
        check1("ovr_still_busy", busy, 1'b1);
        @(negedge clock);
        check1("ovr_still_wait_tx", busy, 1'b1);
        pulse_tx_done();
        check1("ovr_back_idle", busy, 1'b0);
        check1("ovr_sticky", overrun, 1'b1);

        // Back-to-back: operand A on the edge right after tx_done.
        send_byte(8'h10);
        check8("b2b_alu_a", alu_a, 8'h10);
        check1("b2b_busy", busy, 1'b1);
        pulse_tx_done();
        check1("b2b_tx_done_ignored", busy, 1'b1);
        send_byte(8'h06);
        exp_q.push_back(8'h16);
        send_byte(8'h20);
        @(negedge clock);
        check1("b2b_tx_start", tx_start, 1'b1);
        check8("b2b_tx_data", tx_data, 8'h16);
        pulse_tx_done();
        check1("b2b_idle", busy, 1'b0);

        // Mid-sequence reset after operands A and B.
        send_byte(8'h44);
        send_byte(8'h55);
        reset = 1'b0;
        #1;
        check8("mid_rst_alu_a", alu_a, 8'h00);
        check8("mid_rst_alu_b", alu_b, 8'h00);
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_overrun", overrun, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        send_byte(8'h0A);
        check8("post_rst_alu_a", alu_a, 8'h0A);
        send_byte(8'h0B);
        exp_q.push_back(8'h0A);
        send_byte(8'h24);
        @(negedge clock);
        check1("post_rst_tx_start", tx_start, 1'b1);
        check8("post_rst_tx_data", tx_data, 8'h0A);
        pulse_tx_done();

        // Reset during EXEC cancels the pending tx_start.
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h20);
        reset = 1'b0;
        #1;
        check1("exec_rst_busy", busy, 1'b0);
        @(negedge clock);
        check1("exec_rst_no_start", tx_start, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check1("exec_rst_no_start_after", tx_start, 1'b0);

        // Simultaneous rx_done and tx_done in WAIT_TX.
        send_byte(8'h30);
        send_byte(8'h0F);
        exp_q.push_back(8'h3F);
        send_byte(8'h25);
        @(negedge clock);
        rx_data = 8'h99;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clock);
        rx_done = 1'b0;
        tx_done = 1'b0;
        check1("sim_idle", busy, 1'b0);
        check1("sim_overrun", overrun, 1'b1);
        check8("sim_alu_a_kept", alu_a, 8'h30);
        send_byte(8'h01);
        check8("sim_next_is_a", alu_a, 8'h01);
        check1("sim_next_busy", busy, 1'b1);
        do_reset();

        // Randomized transactions against the transaction-level model.
        m_ovr = 1'b0;
        for (int t = 0; t < 40; t++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            hi = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 255));
            else op = {hi, op_list[$urandom_range(0, 7)][5:0]};
            res = alu_model(a, b, op[5:0]);
            gap();
            send_byte(a);
            gap();
            send_byte(b);
            gap();
            exp_q.push_back(res);
            send_byte(op);
            // Edge in EXEC, optionally with a stray byte.
            stray   = ($urandom_range(0, 3) == 0);
            stray_d = 8'($urandom_range(0, 255));
            rx_data = stray_d;
            rx_done = stray;
            @(negedge clock);
            rx_done = 1'b0;
            m_ovr   = m_ovr | stray;
            check1("rand_tx_start", tx_start, 1'b1);
            w = $urandom_range(0, 3);
            repeat (w) begin
                stray   = ($urandom_range(0, 3) == 0);
                rx_data = 8'($urandom_range(0, 255));
                rx_done = stray;
                @(negedge clock);
                rx_done = 1'b0;
                m_ovr   = m_ovr | stray;
            end
            sim     = ($urandom_range(0, 3) == 0);
            rx_data = 8'($urandom_range(0, 255));
            rx_done = sim;
            tx_done = 1'b1;
            @(negedge clock);
            rx_done = 1'b0;
            tx_done = 1'b0;
            m_ovr   = m_ovr | sim;
            check1("rand_idle", busy, 1'b0);
            check1("rand_overrun", overrun, m_ovr);
            check8("rand_alu_a", alu_a, a);
            check8("rand_alu_b", alu_b, b);
            check8("rand_opcode", {2'b00, alu_opcode}, {2'b00, op[5:0]});
            check8("rand_tx_data_hold", tx_data, res);
        end

        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d results never transmitted, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
